vid_rd_ctrl: RTL and testbench

VID_RD_CTRL -- requirements
Module: vid_rd_ctrl

---
 rtl/vid_rd_ctrl_pkg.sv | 23 ++
 rtl/vid_rd_ctrl_if.sv | 14 +
 rtl/vid_burst_addr_gen.sv | 60 ++++++
 rtl/vid_rd_ctrl.sv | 121 ++++++++++++
 tb/tb_vid_rd_ctrl.sv | 327 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/vid_rd_ctrl_pkg.sv
// Shared display constants: frame geometry, beat size and the read-controller
// FSM encoding, so the vga_ctrl side and the DDR side agree on one definition.
package vid_rd_ctrl_pkg;

    localparam int H_PIXELS        = 1280;
    localparam int V_LINES         = 960;
    localparam int PIX_PER_BEAT    = 4;
    localparam int FRAME_BEATS_DEF = H_PIXELS * V_LINES / PIX_PER_BEAT;  // 307200
    localparam int BEAT_BYTES_DEF  = 16;

    localparam int ADDR_W = 30;
    localparam int LEN_W  = 8;
    localparam int CNT_W  = 11;

    typedef enum logic [2:0] {
        IDLE,
        FLUSH,
        CHECK,
        REQ,
        WAIT
    } state_t;

endpackage

// File: rtl/vid_rd_ctrl_if.sv
// Burst read handshake between the frame read controller and the DDR3 read port.
interface vid_rd_ctrl_if;
    import vid_rd_ctrl_pkg::*;

    logic              rd_req;
    logic [ADDR_W-1:0] rd_addr;
    logic [LEN_W-1:0]  rd_len;
    logic              rd_ack;
    logic              rd_done;

    modport master (output rd_req, rd_addr, rd_len, input rd_ack, rd_done);
    modport slave  (input rd_req, rd_addr, rd_len, output rd_ack, rd_done);

endinterface

// File: rtl/vid_burst_addr_gen.sv
// Burst address generator: tracks the next burst start address, the beats
// still to fetch for the frame, and the length of the next burst.
module vid_burst_addr_gen
    import vid_rd_ctrl_pkg::*;
#(
    parameter logic [ADDR_W-1:0] FRAME_BASE  = '0,
    parameter int                FRAME_BEATS = FRAME_BEATS_DEF,
    parameter int                BURST_LEN   = 64,
    parameter int                BEAT_BYTES  = BEAT_BYTES_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,        // rewind to the frame start
    input  logic              advance,     // current burst has completed
    output logic [ADDR_W-1:0] rd_addr,
    output logic [LEN_W-1:0]  rd_len,
    output logic              last_burst   // current burst ends the frame
);

    localparam int BL_W        = $clog2(FRAME_BEATS + 1);
    localparam int FIRST_BEATS = (FRAME_BEATS < BURST_LEN) ? FRAME_BEATS : BURST_LEN;

    logic [BL_W-1:0]  beats_left;
    logic [BL_W-1:0]  left_after;
    logic [LEN_W:0]   burst_beats;
    logic [LEN_W-1:0] len_after;

    assign burst_beats = {1'b0, rd_len} + 1'b1;
    assign left_after  = beats_left - BL_W'(burst_beats);
    assign last_burst  = (beats_left == BL_W'(burst_beats));

    // Length of the burst that follows the current one: full bursts until the
    // tail, then whatever remains; an exhausted frame parks at a full burst.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        len_after = LEN_W'(BURST_LEN - 1);
        if (left_after != '0 && 32'(left_after) < 32'(BURST_LEN)) begin
            len_after = LEN_W'(left_after - 1'b1);
        end
    end

    // Address / remaining-beat / length registers.
    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (!rst_n) begin
            rd_addr    <= FRAME_BASE;
            rd_len     <= LEN_W'(BURST_LEN - 1);
            beats_left <= BL_W'(FRAME_BEATS);
        end else if (load) begin
            rd_addr    <= FRAME_BASE;
            rd_len     <= LEN_W'(FIRST_BEATS - 1);
            beats_left <= BL_W'(FRAME_BEATS);
        end else if (advance) begin
            rd_addr    <= rd_addr + ADDR_W'(burst_beats) * ADDR_W'(BEAT_BYTES);
            rd_len     <= len_after;
            beats_left <= left_after;
        end
    end

endmodule

// File: rtl/vid_rd_ctrl.sv
// Frame read controller: flushes the display FIFO at each frame start, then
// streams the frame from DDR3 as bursts, one outstanding at a time, only
// when the FIFO has room for the whole burst.
module vid_rd_ctrl
    import vid_rd_ctrl_pkg::*;
#(
    parameter logic [ADDR_W-1:0] FRAME_BASE  = 30'h0,
    parameter int                FRAME_BEATS = FRAME_BEATS_DEF,
    parameter int                BURST_LEN   = 64,
    parameter int                FIFO_DEPTH  = 1024,
    parameter int                BEAT_BYTES  = BEAT_BYTES_DEF,
    parameter int                FLUSH_CYC   = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             frame_start,
    input  logic [CNT_W-1:0] fifo_wr_cnt,
    output logic             fifo_rst,
    output logic             frame_err,
    output logic             busy,
    vid_rd_ctrl_if.master    rd
);

    localparam int FC_W = $clog2(FLUSH_CYC + 1);

    state_t            state_q, state_d;
    logic              pending_q, pending_d;
    logic              err_d;
    logic [FC_W-1:0]   flush_cnt_q, flush_cnt_d;
    logic [ADDR_W-1:0] rd_addr;
    logic [LEN_W-1:0]  rd_len;
    logic              last_burst;
    logic              fits;

    vid_burst_addr_gen #(
        .FRAME_BASE  (FRAME_BASE),
        .FRAME_BEATS (FRAME_BEATS),
        .BURST_LEN   (BURST_LEN),
        .BEAT_BYTES  (BEAT_BYTES)
    ) u_addr_gen (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (state_q == FLUSH),
        .advance    ((state_q == WAIT) && rd.rd_done),
        .rd_addr    (rd_addr),
        .rd_len     (rd_len),
        .last_burst (last_burst)
    );

    // 12-bit room check: the sum can never exceed 2047 + 255 + 1.
    assign fits = (12'(fifo_wr_cnt) + 12'(rd_len) + 12'd1) <= 12'(FIFO_DEPTH);

    assign rd.rd_req  = (state_q == REQ);
    assign rd.rd_addr = rd_addr;
    assign rd.rd_len  = rd_len;
    assign busy       = (state_q != IDLE);

    // Next-state, overrun tracking and flush-length counting.
    always_comb begin
        state_d     = state_q;
        pending_d   = pending_q;
        err_d       = 1'b0;
        flush_cnt_d = '0;
        case (state_q)
            IDLE: begin
                if (frame_start) state_d = FLUSH;
            end
            FLUSH: begin
                pending_d = 1'b0;
                if (frame_start) begin
                    flush_cnt_d = '0;                 // restart the flush pulse
                end else if (flush_cnt_q == FC_W'(FLUSH_CYC - 1)) begin
                    state_d = CHECK;
                end else begin
                    flush_cnt_d = flush_cnt_q + FC_W'(1);
                end
            end
            CHECK: begin
                if (frame_start)  state_d = FLUSH;
                else if (fits)    state_d = REQ;
            end
            REQ: begin
                if (frame_start) begin
                    pending_d = 1'b1;
                    err_d     = 1'b1;
                end
                if (rd.rd_ack) state_d = WAIT;
            end
            WAIT: begin
                if (frame_start) begin
                    pending_d = 1'b1;
                    err_d     = 1'b1;
                end
                if (rd.rd_done) begin
                    if (pending_d)       state_d = FLUSH;
                    else if (last_burst) state_d = IDLE;
                    else                 state_d = CHECK;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and registered outputs; fifo_rst is held during reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            pending_q   <= 1'b0;
            frame_err   <= 1'b0;
            fifo_rst    <= 1'b1;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            pending_q   <= pending_d;
            frame_err   <= err_d;
            fifo_rst    <= (state_d == FLUSH);
            flush_cnt_q <= flush_cnt_d;
        end
    end

endmodule

// File: tb/tb_vid_rd_ctrl.sv
// Directed bench for vid_rd_ctrl with a 200-beat frame, 64-beat bursts and a
// 256-beat FIFO.
module tb_vid_rd_ctrl;

    logic        clk;
    logic        rst_n;
    logic        frame_start;
    logic [10:0] fifo_wr_cnt;
    logic        fifo_rst;
    logic        frame_err;
    logic        busy;

    int errors = 0;
    int checks = 0;

    vid_rd_ctrl_if rd_if ();

    vid_rd_ctrl #(
        .FRAME_BASE  (30'h0),
        .FRAME_BEATS (200),
        .BURST_LEN   (64),
        .FIFO_DEPTH  (256),
        .BEAT_BYTES  (16),
        .FLUSH_CYC   (8)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .frame_start (frame_start),
        .fifo_wr_cnt (fifo_wr_cnt),
        .fifo_rst    (fifo_rst),
        .frame_err   (frame_err),
        .busy        (busy),
        .rd          (rd_if)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst_n           = 1'b0;
        frame_start     = 1'b0;
        fifo_wr_cnt     = '0;
        rd_if.rd_ack    = 1'b0;
        rd_if.rd_done   = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic pulse_start();
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
    endtask

    task automatic count_flush(output int n);
        n = 0;
        while (fifo_rst === 1'b1 && n < 40) begin
            n++;
            tick();
        end
    endtask

    // Wait for a request, check it, then ack and complete it 2 cycles apart.
    task automatic do_burst(input logic [29:0] exp_addr, input logic [7:0] exp_len,
                            input string name);
        int n = 0;
        while (rd_if.rd_req !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        checks++;
        if (rd_if.rd_req !== 1'b1) begin
            errors++;
            $display("FAIL %s_req: rd_req=%b, expected 1 within 40 cycles", name, rd_if.rd_req);
            return;
        end
        checks++;
        if (rd_if.rd_addr !== exp_addr || rd_if.rd_len !== exp_len) begin
            errors++;
            $display("FAIL %s_burst: addr=%0d len=%0d, expected addr=%0d len=%0d",
                     name, rd_if.rd_addr, rd_if.rd_len, exp_addr, exp_len);
        end
        tick();
        tick();
        checks++;
        if (rd_if.rd_req !== 1'b1 || rd_if.rd_addr !== exp_addr) begin
            errors++;
            $display("FAIL %s_stable: req=%b addr=%0d, expected req=1 addr=%0d",
                     name, rd_if.rd_req, rd_if.rd_addr, exp_addr);
        end
        rd_if.rd_ack = 1'b1;
        tick();
        rd_if.rd_ack = 1'b0;
        checks++;
        if (rd_if.rd_req !== 1'b0) begin
            errors++;
            $display("FAIL %s_req_drop: rd_req=%b, expected 0", name, rd_if.rd_req);
        end
        tick();
        tick();
        rd_if.rd_done = 1'b1;
        tick();
        rd_if.rd_done = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        frame_start = 1'b0;
        fifo_wr_cnt = '0;
        rd_if.rd_ack = 1'b0;
        rd_if.rd_done = 1'b0;
        tick();
        checks++;
        if (fifo_rst !== 1'b1 || rd_if.rd_req !== 1'b0 || busy !== 1'b0 || frame_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_ctrl: fifo_rst=%b req=%b busy=%b err=%b, expected 1 0 0 0",
                     fifo_rst, rd_if.rd_req, busy, frame_err);
        end
        checks++;
        if (rd_if.rd_addr !== 30'd0 || rd_if.rd_len !== 8'd63) begin
            errors++;
            $display("FAIL reset_burst: addr=%0d len=%0d, expected 0 63", rd_if.rd_addr, rd_if.rd_len);
        end
        rst_n = 1'b1;
        rd_if.rd_done = 1'b1;           // stray completion in IDLE
        tick();
        rd_if.rd_done = 1'b0;
        tick();
        checks++;
        if (fifo_rst !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle: fifo_rst=%b busy=%b, expected 0 0", fifo_rst, busy);
        end
    endtask

    task automatic test_full_frame();
        int n;
        apply_reset();
        pulse_start();
        checks++;
        if (frame_err !== 1'b0) begin
            errors++;
            $display("FAIL frame_idle_err: frame_err=%b, expected 0", frame_err);
        end
        count_flush(n);
        checks++;
        if (n != 8) begin
            errors++;
            $display("FAIL frame_flush_len: fifo_rst high %0d cycles, expected 8", n);
        end
        do_burst(30'd0,    8'd63, "frame_b0");
        do_burst(30'd1024, 8'd63, "frame_b1");
        do_burst(30'd2048, 8'd63, "frame_b2");
        do_burst(30'd3072, 8'd7,  "frame_b3");
        checks++;
        if (busy !== 1'b0 || fifo_rst !== 1'b0 || rd_if.rd_req !== 1'b0) begin
            errors++;
            $display("FAIL frame_end: busy=%b fifo_rst=%b req=%b, expected 0 0 0",
                     busy, fifo_rst, rd_if.rd_req);
        end
        pulse_start();
        checks++;
        if (frame_err !== 1'b0 || fifo_rst !== 1'b1) begin
            errors++;
            $display("FAIL frame_restart: err=%b fifo_rst=%b, expected 0 1", frame_err, fifo_rst);
        end
    endtask

    task automatic test_fifo_full();
        apply_reset();
        fifo_wr_cnt = 11'd200;
        pulse_start();
        repeat (12) tick();
        checks++;
        if (rd_if.rd_req !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL full_hold200: req=%b busy=%b, expected 0 1", rd_if.rd_req, busy);
        end
        fifo_wr_cnt = 11'd193;
        repeat (3) tick();
        checks++;
        if (rd_if.rd_req !== 1'b0) begin
            errors++;
            $display("FAIL full_hold193: req=%b, expected 0", rd_if.rd_req);
        end
        fifo_wr_cnt = 11'd192;
        tick();
        checks++;
        if (rd_if.rd_req !== 1'b1 || rd_if.rd_addr !== 30'd0) begin
            errors++;
            $display("FAIL full_fit192: req=%b addr=%0d, expected 1 0", rd_if.rd_req, rd_if.rd_addr);
        end
    endtask

    task automatic test_frame_overrun();
        apply_reset();
        pulse_start();
        do_burst(30'd0, 8'd63, "ovr_b0");
        while (rd_if.rd_req !== 1'b1 && busy === 1'b1) tick();
        checks++;
        if (rd_if.rd_addr !== 30'd1024) begin
            errors++;
            $display("FAIL ovr_b1_addr: addr=%0d, expected 1024", rd_if.rd_addr);
        end
        rd_if.rd_ack = 1'b1;
        tick();
        rd_if.rd_ack = 1'b0;
        tick();
        pulse_start();
        checks++;
        if (frame_err !== 1'b1 || fifo_rst !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL ovr_err_pulse: err=%b fifo_rst=%b busy=%b, expected 1 0 1",
                     frame_err, fifo_rst, busy);
        end
        tick();
        checks++;
        if (frame_err !== 1'b0 || fifo_rst !== 1'b0) begin
            errors++;
            $display("FAIL ovr_err_single: err=%b fifo_rst=%b, expected 0 0", frame_err, fifo_rst);
        end
        rd_if.rd_done = 1'b1;
        tick();
        rd_if.rd_done = 1'b0;
        checks++;
        if (fifo_rst !== 1'b1 || rd_if.rd_req !== 1'b0) begin
            errors++;
            $display("FAIL ovr_flush: fifo_rst=%b req=%b, expected 1 0", fifo_rst, rd_if.rd_req);
        end
        do_burst(30'd0, 8'd63, "ovr_new_b0");
    endtask

    task automatic test_check_start();
        int n;
        apply_reset();
        fifo_wr_cnt = 11'd250;
        pulse_start();
        repeat (10) tick();
        rd_if.rd_ack = 1'b1;             // stray ack while waiting for room
        tick();
        rd_if.rd_ack = 1'b0;
        tick();
        checks++;
        if (rd_if.rd_req !== 1'b0 || busy !== 1'b1 || fifo_rst !== 1'b0) begin
            errors++;
            $display("FAIL chk_spurious_ack: req=%b busy=%b fifo_rst=%b, expected 0 1 0",
                     rd_if.rd_req, busy, fifo_rst);
        end
        fifo_wr_cnt = 11'd0;             // room appears together with frame start
        pulse_start();
        checks++;
        if (rd_if.rd_req !== 1'b0 || fifo_rst !== 1'b1 || frame_err !== 1'b0) begin
            errors++;
            $display("FAIL chk_start: req=%b fifo_rst=%b err=%b, expected 0 1 0",
                     rd_if.rd_req, fifo_rst, frame_err);
        end
        count_flush(n);
        checks++;
        if (n != 8) begin
            errors++;
            $display("FAIL chk_flush_len: fifo_rst high %0d cycles, expected 8", n);
        end
    endtask

    task automatic test_flush_restart();
        int n;
        apply_reset();
        pulse_start();
        repeat (3) tick();
        pulse_start();
        count_flush(n);
        checks++;
        if (n != 8) begin
            errors++;
            $display("FAIL flush_restart: fifo_rst high %0d cycles after restart, expected 8", n);
        end
    endtask

    task automatic test_reset_mid();
        apply_reset();
        pulse_start();
        do_burst(30'd0, 8'd63, "rstm_b0");
        while (rd_if.rd_req !== 1'b1 && busy === 1'b1) tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        checks++;
        if (rd_if.rd_req !== 1'b0 || fifo_rst !== 1'b1 || busy !== 1'b0 || rd_if.rd_addr !== 30'd0) begin
            errors++;
            $display("FAIL rstm_state: req=%b fifo_rst=%b busy=%b addr=%0d, expected 0 1 0 0",
                     rd_if.rd_req, fifo_rst, busy, rd_if.rd_addr);
        end
        tick();
        checks++;
        if (fifo_rst !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL rstm_idle: fifo_rst=%b busy=%b, expected 0 0", fifo_rst, busy);
        end
    endtask

    initial begin
        test_reset();
        test_full_frame();
        test_fifo_full();
        test_frame_overrun();
        test_check_start();
        test_flush_restart();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded 200000 time units");
        $fatal(1);
    end

endmodule
